// File: rtl/definitions_pkg.sv
// definitions_pkg: shared types and constants for the Canny front end.
//   IMAGE_WIDTH  default pixels per line
//   pixel_t      8-bit grayscale pixel
//   window_t     3x3 window, top row in the MSBs, leftmost pixel first in each row
//   win_state_e  window read-side FSM states
package definitions_pkg;
  localparam int IMAGE_WIDTH = 512;

  typedef logic [7:0]  pixel_t;
  typedef logic [71:0] window_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } win_state_e;
endpackage

// File: rtl/window_line_ram.sv
// window_line_ram: storage for one image line.
//   clk        clock, rising edge
//   i_we       write enable
//   i_wr_addr  write column
//   i_wr_data  pixel to store
//   i_rd_addr  leftmost column of the three read taps
//   o_tap0/1/2 combinational pixels at i_rd_addr, +1, +2
module window_line_ram
  import definitions_pkg::*;
#(
  parameter int IMAGE_WIDTH = definitions_pkg::IMAGE_WIDTH,
  parameter int AW          = $clog2(IMAGE_WIDTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  pixel_t        i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output pixel_t        o_tap0,
  output pixel_t        o_tap1,
  output pixel_t        o_tap2
);

  pixel_t mem_q [IMAGE_WIDTH];

  // Line contents are never reset; stale data is unreachable until overwritten.
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  // The read address never exceeds IMAGE_WIDTH-3, so the +2 tap stays in range.
  assign o_tap0 = mem_q[i_rd_addr];
  assign o_tap1 = mem_q[i_rd_addr + AW'(1)];
  assign o_tap2 = mem_q[i_rd_addr + AW'(2)];

endmodule

// File: rtl/window_controller.sv
// window_controller: writes a raster pixel stream into four rotating line
// stores and, once three lines are resident, reads them back as 3x3 windows.
//   clk, rst        clock and synchronous active-high reset
//   i_pixel         incoming pixel, taken when i_pixel_valid && o_pixel_ready
//   o_pixel_ready   low only when all four line stores are full
//   o_window        registered 3x3 window (top row [71:48], bottom row [23:0])
//   o_window_valid  o_window holds an unconsumed window
//   i_window_ready  downstream accepts o_window
//   o_line_done     one-cycle pulse when the top line is released
module window_controller
  import definitions_pkg::*;
#(
  parameter int IMAGE_WIDTH = definitions_pkg::IMAGE_WIDTH
) (
  input  logic    clk,
  input  logic    rst,
  input  pixel_t  i_pixel,
  input  logic    i_pixel_valid,
  output logic    o_pixel_ready,
  output window_t o_window,
  output logic    o_window_valid,
  input  logic    i_window_ready,
  output logic    o_line_done
);

  localparam int AW = $clog2(IMAGE_WIDTH);
  localparam int CW = $clog2(4 * IMAGE_WIDTH + 1);

  localparam logic [AW-1:0] LAST_WR_COL = AW'(IMAGE_WIDTH - 1);
  localparam logic [AW-1:0] LAST_RD_COL = AW'(IMAGE_WIDTH - 3);
  localparam logic [CW-1:0] LINE_CNT    = CW'(IMAGE_WIDTH);
  localparam logic [CW-1:0] READ_CNT    = CW'(3 * IMAGE_WIDTH);
  localparam logic [CW-1:0] FULL_CNT    = CW'(4 * IMAGE_WIDTH);

  win_state_e    state_q, state_d;
  logic [1:0]    wr_sel_q, wr_sel_d;
  logic [AW-1:0] wr_col_q, wr_col_d;
  logic [1:0]    rd_sel_q, rd_sel_d;
  logic [AW-1:0] rd_col_q, rd_col_d;
  logic [CW-1:0] stored_q, stored_d;
  window_t       window_q, window_d;
  logic          window_valid_q, window_valid_d;
  logic          line_done_q, line_done_d;

  logic          wr_accept;
  logic          release_line;
  logic [3:0]    line_we;
  logic [1:0]    mid_sel, bot_sel;
  pixel_t        tap0 [4];
  pixel_t        tap1 [4];
  pixel_t        tap2 [4];
  logic [23:0]   row_taps [4];

  for (genvar g = 0; g < 4; g++) begin : g_line
    window_line_ram #(
      .IMAGE_WIDTH(IMAGE_WIDTH),
      .AW         (AW)
    ) u_line (
      .clk      (clk),
      .i_we     (line_we[g]),
      .i_wr_addr(wr_col_q),
      .i_wr_data(i_pixel),
      .i_rd_addr(rd_col_q),
      .o_tap0   (tap0[g]),
      .o_tap1   (tap1[g]),
      .o_tap2   (tap2[g])
    );
    assign row_taps[g] = {tap0[g], tap1[g], tap2[g]};
  end

  assign o_pixel_ready = (stored_q != FULL_CNT);
  assign wr_accept     = i_pixel_valid && o_pixel_ready;

  // 2-bit selects wrap modulo 4 on their own.
  assign mid_sel = rd_sel_q + 2'd1;
  assign bot_sel = rd_sel_q + 2'd2;

  // Write position and fill count.
  always_comb begin
    wr_sel_d = wr_sel_q;
    wr_col_d = wr_col_q;
    stored_d = stored_q;
    for (int i = 0; i < 4; i++) begin
      line_we[i] = wr_accept && (wr_sel_q == 2'(i));
    end
    if (wr_accept) begin
      if (wr_col_q == LAST_WR_COL) begin
        wr_col_d = '0;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_col_d = wr_col_q + AW'(1);
      end
    end
    case ({wr_accept, release_line})
      2'b10:   stored_d = stored_q + CW'(1);
      2'b01:   stored_d = stored_q - LINE_CNT;
      2'b11:   stored_d = stored_q + CW'(1) - LINE_CNT;
      default: stored_d = stored_q;
    endcase
  end

  // Read-side FSM. READ is only occupied while columns remain to be loaded,
  // so being in READ already implies a pending column.
  always_comb begin
    state_d        = state_q;
    rd_sel_d       = rd_sel_q;
    rd_col_d       = rd_col_q;
    window_d       = window_q;
    window_valid_d = window_valid_q;
    line_done_d    = 1'b0;
    release_line   = 1'b0;
    case (state_q)
      IDLE: begin
        if (stored_q >= READ_CNT) begin
          state_d = READ;
        end
      end
      READ: begin
        if (!window_valid_q || i_window_ready) begin
          window_d       = {row_taps[rd_sel_q], row_taps[mid_sel], row_taps[bot_sel]};
          window_valid_d = 1'b1;
          if (rd_col_q == LAST_RD_COL) begin
            state_d = DRAIN;
          end else begin
            rd_col_d = rd_col_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        // Nothing new is loaded here, leaving a bubble before the next row.
        if (window_valid_q && i_window_ready) begin
          window_valid_d = 1'b0;
          rd_sel_d       = rd_sel_q + 2'd1;
          rd_col_d       = '0;
          line_done_d    = 1'b1;
          release_line   = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_sel_q       <= '0;
      wr_col_q       <= '0;
      rd_sel_q       <= '0;
      rd_col_q       <= '0;
      stored_q       <= '0;
      window_q       <= '0;
      window_valid_q <= 1'b0;
      line_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_sel_q       <= wr_sel_d;
      wr_col_q       <= wr_col_d;
      rd_sel_q       <= rd_sel_d;
      rd_col_q       <= rd_col_d;
      stored_q       <= stored_d;
      window_q       <= window_d;
      window_valid_q <= window_valid_d;
      line_done_q    <= line_done_d;
    end
  end

  assign o_window       = window_q;
  assign o_window_valid = window_valid_q;
  assign o_line_done    = line_done_q;

endmodule

// File: tb/tb_window_controller.sv
// tb_window_controller: stimulus for window_controller with a scoreboard fed by
// a line-level reference model (list of accepted pixels, windows cut from it).
module tb_window_controller;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_pixel = 8'd0;
  logic        i_pixel_valid = 1'b0;
  logic        o_pixel_ready;
  logic [71:0] o_window;
  logic        o_window_valid;
  logic        i_window_ready = 1'b1;
  logic        o_line_done;

  always #5 clk = ~clk;

  window_controller #(.IMAGE_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pixel       (i_pixel),
    .i_pixel_valid (i_pixel_valid),
    .o_pixel_ready (o_pixel_ready),
    .o_window      (o_window),
    .o_window_valid(o_window_valid),
    .i_window_ready(i_window_ready),
    .o_line_done   (o_line_done)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  frame[$];
  logic [71:0] exp_q[$];
  int          model_stored = 0;
  int          consumed = 0;
  int          cyc = 0;
  int          wr3_cyc = 0;
  int          ld_pulses = 0;
  bit          got_wr3 = 0;
  bit          first_seen = 0;
  logic        prev_valid = 1'b0;
  logic [71:0] prev_win = '0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Window with top row r, leftmost column c, taken from the accepted pixel list.
  function automatic logic [71:0] make_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        w = {w[63:0], frame[(r + k) * W + c + j]};
      end
    end
    return w;
  endfunction

  // Monitor / scoreboard: runs 1 time unit after every rising edge.
  initial begin
    bit wr_acc;
    bit win_acc;
    bit rel;
    int r;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        frame.delete();
        exp_q.delete();
        model_stored = 0;
        consumed     = 0;
        got_wr3      = 0;
        first_seen   = 0;
        check("reset_window", o_window, 72'd0);
        check("reset_valid", o_window_valid, 1'b0);
        check("reset_line_done", o_line_done, 1'b0);
        check("reset_ready", o_pixel_ready, 1'b1);
        prev_valid = 1'b0;
        prev_win   = '0;
      end else begin
        wr_acc  = i_pixel_valid && (model_stored != 4 * W);
        win_acc = prev_valid && i_window_ready;
        rel     = 0;
        if (win_acc) begin
          consumed++;
          if (consumed % (W - 2) == 0) begin
            rel = 1;
            model_stored -= W;
          end
        end
        if (wr_acc) begin
          frame.push_back(i_pixel);
          model_stored++;
          if (frame.size() == 3 * W && !got_wr3) begin
            got_wr3 = 1;
            wr3_cyc = cyc;
          end
          if (frame.size() % W == 0 && frame.size() >= 3 * W) begin
            r = frame.size() / W - 3;
            for (int c = 0; c < W - 2; c++) exp_q.push_back(make_win(r, c));
          end
        end
        check("line_done", o_line_done, rel);
        if (o_line_done) ld_pulses++;
        check("pixel_ready", o_pixel_ready, (model_stored != 4 * W));
        if (prev_valid && !i_window_ready) begin
          check("hold_valid", o_window_valid, 1'b1);
          check("hold_window", o_window, prev_win);
        end else if (o_window_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_window: got %h expected none", o_window);
          end else begin
            check("window", o_window, exp_q.pop_front());
          end
          if (!first_seen) begin
            first_seen = 1;
            check("first_latency", 72'(cyc - wr3_cyc), 72'd2);
          end
        end
        prev_valid = o_window_valid;
        prev_win   = o_window;
      end
    end
  end

  task automatic drive(input logic rs, input logic v, input logic [7:0] p, input logic rdy);
    @(negedge clk);
    rst            = rs;
    i_pixel_valid  = v;
    i_pixel        = p;
    i_window_ready = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) drive(1'b0, 1'b0, 8'd0, rdy);
  endtask

  task automatic do_reset(input int n);
    repeat (n) drive(1'b1, 1'b1, 8'hAA, 1'b1);
  endtask

  task automatic stream(input int n, input int base, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 8'(base + i), rdy);
  endtask

  initial begin
    // Reset with pixels offered: nothing may be stored.
    do_reset(2);

    // First row of windows.
    stream(24, 0, 1'b1);
    idle(15, 1'b1);
    check("empty_after_row", 72'(exp_q.size()), 72'd0);

    // Backpressure at the second window.
    do_reset(1);
    stream(24, 0, 1'b1);
    idle(3, 1'b1);
    idle(5, 1'b0);
    idle(20, 1'b1);
    check("empty_after_stall", 72'(exp_q.size()), 72'd0);

    // Full: 40 pixels offered with no reads.
    do_reset(1);
    stream(40, 0, 1'b0);
    check("full_ready_low", o_pixel_ready, 1'b0);
    idle(40, 1'b1);
    check("empty_after_full", 72'(exp_q.size()), 72'd0);

    // Wrap-around: 7 rows with continuous draining.
    do_reset(1);
    ld_pulses = 0;
    stream(56, 0, 1'b1);
    idle(40, 1'b1);
    check("line_done_count", 72'(ld_pulses), 72'd5);
    check("empty_after_wrap", 72'(exp_q.size()), 72'd0);

    // Mid-frame reset during the third window, then fresh pixels.
    do_reset(1);
    stream(24, 0, 1'b1);
    idle(4, 1'b1);
    do_reset(1);
    stream(24, 100, 1'b1);
    idle(15, 1'b1);
    check("empty_after_midreset", 72'(exp_q.size()), 72'd0);

    // Randomized traffic on both sides.
    do_reset(1);
    repeat (300) begin
      drive(1'b0, ($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 6));
    end
    idle(80, 1'b1);
    check("empty_after_random", 72'(exp_q.size()), 72'd0);

    idle(2, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
